cpu_core_param: RTL and testbench

Parametrised successor to the fixed 19-bit CPU core. It executes one instruction per valid/ready handshake, using a configurable datapath width and register-file depth. MUL is multi-cycle (shift-add), and ENC/DEC are keyed rotate-XOR operations. The block adds carry/zero flags, an immediate load, a conditional jump and sticky illegal-opcode detection. Instructions come from an external sequencer or instruction memory.

---
 rtl/cpu_core_param.sv | 178 +++++++++++++++++
 tb/tb_cpu_core_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_param.sv
// Parametrised single-issue CPU core: one instruction per valid/ready handshake,
// multi-cycle shift-add MUL, keyed rotate-XOR ENC/DEC, carry/zero/illegal flags.
module cpu_core_param #(
    parameter int unsigned WIDTH   = 19,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned ENC_KEY = 32'h15A5A,
    parameter int unsigned ENC_ROT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instruction,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] addr,
    output logic             done,
    output logic             carry,
    output logic             zero,
    output logic             illegal
);
    localparam int unsigned NREGS = 2**REG_AW;
    localparam int unsigned IMM_W = WIDTH - 5 - REG_AW;
    localparam int unsigned JT_W  = WIDTH - 5;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] KEY = WIDTH'(ENC_KEY);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_INC = 5'b00011;
    localparam logic [4:0] OP_DCR = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_OR  = 5'b00111;
    localparam logic [4:0] OP_XOR = 5'b01000;
    localparam logic [4:0] OP_NOT = 5'b01001;
    localparam logic [4:0] OP_JMP = 5'b01010;
    localparam logic [4:0] OP_JZ  = 5'b01011;
    localparam logic [4:0] OP_LDI = 5'b01100;
    localparam logic [4:0] OP_NOP = 5'b01111;
    localparam logic [4:0] OP_ENC = 5'b10010;
    localparam logic [4:0] OP_DEC = 5'b10011;

    typedef enum logic {IDLE, MULT} state_t;

    state_t              state;
    logic [WIDTH-1:0]    regs [NREGS];
    logic [WIDTH-1:0]    m_a, m_b, m_acc, m_next;
    logic [REG_AW-1:0]   m_rd;
    logic [CNT_W-1:0]    cnt;

    logic [4:0]          op;
    logic [REG_AW-1:0]   rd, rs1, rs2;
    logic [WIDTH-1:0]    imm, jtgt, a, b, d;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    res, tgt;
    logic                res_c, wr, legal, take;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x);
        return (x << ENC_ROT) | (x >> (WIDTH - ENC_ROT));
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x);
        return (x >> ENC_ROT) | (x << (WIDTH - ENC_ROT));
    endfunction

    // Field decode and operand read (old register values, so rd==rs1 is safe)
    assign op     = instruction[WIDTH-1 -: 5];
    assign rd     = instruction[WIDTH-6 -: REG_AW];
    assign rs1    = instruction[WIDTH-6-REG_AW -: REG_AW];
    assign rs2    = instruction[WIDTH-6-2*REG_AW -: REG_AW];
    assign imm    = WIDTH'(instruction[IMM_W-1:0]);
    assign jtgt   = WIDTH'(instruction[JT_W-1:0]);
    assign a      = regs[rs1];
    assign b      = regs[rs2];
    assign d      = regs[rd];
    assign sum    = {1'b0, a} + {1'b0, b};
    assign m_next = m_acc + (m_b[0] ? m_a : '0);

    // Single-cycle execute for everything except MUL
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        wr    = 1'b0;
        legal = 1'b1;
        take  = 1'b0;
        tgt   = '0;
        case (op)
            OP_ADD: begin res = sum[WIDTH-1:0];     res_c = sum[WIDTH]; wr = 1'b1; end
            OP_SUB: begin res = a - b;              res_c = (a < b);    wr = 1'b1; end
            OP_MUL: ;
            OP_INC: begin res = a + WIDTH'(1);      res_c = &a;         wr = 1'b1; end
            OP_DCR: begin res = a - WIDTH'(1);      res_c = ~|a;        wr = 1'b1; end
            OP_AND: begin res = a & b;              wr = 1'b1; end
            OP_OR:  begin res = a | b;              wr = 1'b1; end
            OP_XOR: begin res = a ^ b;              wr = 1'b1; end
            OP_NOT: begin res = ~a;                 wr = 1'b1; end
            OP_JMP: begin take = 1'b1;              tgt = jtgt; end
            OP_JZ:  begin take = ~|d;               tgt = imm;  end
            OP_LDI: begin res = imm;                wr = 1'b1; end
            OP_NOP: ;
            OP_ENC: begin res = rotl(a) ^ KEY;      wr = 1'b1; end
            OP_DEC: begin res = rotr(a ^ KEY);      wr = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            pc          <= '0;
            data_out    <= '0;
            addr        <= '0;
            done        <= 1'b0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            illegal     <= 1'b0;
            m_a         <= '0;
            m_b         <= '0;
            m_acc       <= '0;
            m_rd        <= '0;
            cnt         <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (op == OP_MUL) begin
                            m_a         <= a;
                            m_b         <= b;
                            m_acc       <= '0;
                            m_rd        <= rd;
                            cnt         <= '0;
                            state       <= MULT;
                            instr_ready <= 1'b0;
                        end else begin
                            if (wr) begin
                                regs[rd] <= res;
                                data_out <= res;
                                addr     <= WIDTH'(rd);
                                carry    <= res_c;
                                zero     <= (res == '0);
                            end
                            if (take) begin
                                pc   <= tgt;
                                addr <= tgt;
                            end else begin
                                pc <= pc + WIDTH'(1);
                            end
                            if (!legal) illegal <= 1'b1;
                            done <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    // One partial product per edge; last step retires directly
                    m_acc <= m_next;
                    m_a   <= m_a << 1;
                    m_b   <= m_b >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        regs[m_rd]  <= m_next;
                        data_out    <= m_next;
                        addr        <= WIDTH'(m_rd);
                        zero        <= (m_next == '0);
                        pc          <= pc + WIDTH'(1);
                        done        <= 1'b1;
                        instr_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core_param.sv
// Directed bench for cpu_core_param: expected retire results are queued on issue
// and popped when done pulses; a second 32-bit instance checks ENC/DEC round trip.
module tb_cpu_core_param;
    localparam int unsigned W  = 19;
    localparam int unsigned W2 = 32;

    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, MUL = 5'b00010, INC = 5'b00011;
    localparam logic [4:0] DCR = 5'b00100, XOR = 5'b01000, NOT = 5'b01001, JMP = 5'b01010;
    localparam logic [4:0] JZ  = 5'b01011, LDI = 5'b01100, NOP = 5'b01111, ENC = 5'b10010;
    localparam logic [4:0] DEC = 5'b10011, ILL = 5'b11111;

    typedef struct packed {
        logic [W-1:0] d;
        logic [W-1:0] pc;
        logic [W-1:0] addr;
        logic         c;
        logic         z;
        logic         il;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  instruction;
    logic          instr_valid;
    logic          instr_ready;
    logic [W-1:0]  pc, data_out, addr;
    logic          done, carry, zero, illegal;

    logic [W2-1:0] instruction_w;
    logic          instr_valid_w;
    logic          instr_ready_w;
    logic [W2-1:0] pc_w, data_out_w, addr_w;
    logic          done_w, carry_w, zero_w, illegal_w;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cpu_core_param dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .data_out(data_out), .addr(addr),
        .done(done), .carry(carry), .zero(zero), .illegal(illegal)
    );

    cpu_core_param #(.WIDTH(32), .REG_AW(5)) dut_w (
        .clk(clk), .rst(rst), .instruction(instruction_w), .instr_valid(instr_valid_w),
        .instr_ready(instr_ready_w), .pc(pc_w), .data_out(data_out_w), .addr(addr_w),
        .done(done_w), .carry(carry_w), .zero(zero_w), .illegal(illegal_w)
    );

    function automatic logic [W-1:0] mk_r(input logic [4:0] op, input int rd, input int r1, input int r2);
        return {op, 4'(rd), 4'(r1), 4'(r2), 2'b00};
    endfunction

    function automatic logic [W-1:0] mk_i(input logic [4:0] op, input int rd, input int imm);
        return {op, 4'(rd), 10'(imm)};
    endfunction

    function automatic logic [W-1:0] mk_j(input logic [4:0] op, input int tgt);
        return {op, 14'(tgt)};
    endfunction

    function automatic exp_t mk_e(input int d, input int p, input int a, input int c, input int z, input int il);
        exp_t e;
        e.d    = W'(d);
        e.pc   = W'(p);
        e.addr = W'(a);
        e.c    = 1'(c);
        e.z    = 1'(z);
        e.il   = 1'(il);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where done should be high
    task automatic retire(input string tag);
        exp_t e;
        chk({tag, "_done"}, 32'(done), 32'd1);
        e = sb.pop_front();
        chk({tag, "_data"}, 32'(data_out), 32'(e.d));
        chk({tag, "_pc"},   32'(pc),       32'(e.pc));
        chk({tag, "_addr"}, 32'(addr),     32'(e.addr));
        chk({tag, "_czi"},  32'({carry, zero, illegal}), 32'({e.c, e.z, e.il}));
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    task automatic issue(input string tag, input logic [W-1:0] ins, input exp_t e);
        int n;
        @(negedge clk);
        instruction = ins;
        instr_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        instr_valid = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        retire(tag);
    endtask

    task automatic issue_w(input string tag, input logic [W2-1:0] ins, input logic [W2-1:0] exp);
        int n;
        @(negedge clk);
        instruction_w = ins;
        instr_valid_w = 1'b1;
        @(negedge clk);
        instr_valid_w = 1'b0;
        n = 0;
        while (!done_w && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done_w), 32'd1);
        chk({tag, "_data"}, data_out_w, exp);
    endtask

    initial begin
        int low;
        int n;
        rst           = 1'b1;
        instruction   = '0;
        instr_valid   = 1'b0;
        instruction_w = '0;
        instr_valid_w = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc",    32'(pc),       32'd0);
        chk("rst_data",  32'(data_out), 32'd0);
        chk("rst_addr",  32'(addr),     32'd0);
        chk("rst_flags", 32'({done, carry, zero, illegal}), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        rst = 1'b0;

        issue("ldi_r1",   mk_i(LDI, 1, 5),      mk_e(5, 1, 1, 0, 0, 0));
        issue("ldi_r2",   mk_i(LDI, 2, 3),      mk_e(3, 2, 2, 0, 0, 0));
        issue("add_r3",   mk_r(ADD, 3, 1, 2),   mk_e(8, 3, 3, 0, 0, 0));
        issue("sub_neg",  mk_r(SUB, 4, 2, 1),   mk_e(32'h7FFFE, 4, 4, 1, 0, 0));
        issue("sub_zero", mk_r(SUB, 5, 1, 1),   mk_e(0, 5, 5, 0, 1, 0));

        // MUL with a junk LDI held valid for the whole multiply; it must be ignored
        @(negedge clk);
        instruction = mk_r(MUL, 6, 1, 2);
        instr_valid = 1'b1;
        sb.push_back(mk_e(15, 6, 6, 0, 0, 0));
        @(negedge clk);
        instruction = mk_i(LDI, 1, 777);
        low = 0;
        n   = 0;
        while (!done && n < 40) begin
            if (!instr_ready) low++;
            @(negedge clk);
            n++;
        end
        instr_valid = 1'b0;
        chk("mul_busy_cycles", 32'(low), 32'd19);
        chk("mul_ready_back",  32'(instr_ready), 32'd1);
        retire("mul");

        issue("enc_r7",   mk_r(ENC, 7, 1, 0),   mk_e(32'h15A72, 7, 7, 0, 0, 0));
        issue("dec_r8",   mk_r(DEC, 8, 7, 0),   mk_e(5, 8, 8, 0, 0, 0));
        issue("jmp_3",    mk_j(JMP, 3),         mk_e(5, 3, 3, 0, 0, 0));
        issue("jz_taken", mk_i(JZ, 5, 9),       mk_e(5, 9, 9, 0, 0, 0));
        issue("jz_not",   mk_i(JZ, 1, 20),      mk_e(5, 10, 9, 0, 0, 0));
        issue("not_r11",  mk_r(NOT, 11, 0, 0),  mk_e(32'h7FFFF, 11, 11, 0, 0, 0));
        issue("inc_wrap", mk_r(INC, 12, 11, 0), mk_e(0, 12, 12, 1, 1, 0));
        issue("dcr_wrap", mk_r(DCR, 13, 0, 0),  mk_e(32'h7FFFF, 13, 13, 1, 0, 0));
        issue("add_cout", mk_r(ADD, 14, 11, 1), mk_e(4, 14, 14, 1, 0, 0));
        issue("nop",      mk_r(NOP, 0, 0, 0),   mk_e(4, 15, 14, 1, 0, 0));
        issue("illegal",  mk_r(ILL, 0, 0, 0),   mk_e(4, 16, 14, 1, 0, 1));
        issue("add_stky", mk_r(ADD, 3, 1, 2),   mk_e(8, 17, 3, 0, 0, 1));
        issue("xor_r9",   mk_r(XOR, 9, 1, 2),   mk_e(6, 18, 9, 0, 0, 1));

        // Reset during a MUL, with a competing accept on the reset edge
        @(negedge clk);
        instruction = mk_r(MUL, 6, 1, 1);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        instruction = mk_i(LDI, 1, 7);
        instr_valid = 1'b1;
        rst         = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        instr_valid = 1'b0;
        chk("mrst_pc",    32'(pc),       32'd0);
        chk("mrst_data",  32'(data_out), 32'd0);
        chk("mrst_addr",  32'(addr),     32'd0);
        chk("mrst_flags", 32'({done, carry, zero, illegal}), 32'd0);
        chk("mrst_ready", 32'(instr_ready), 32'd1);
        issue("post_rst", mk_r(ADD, 3, 1, 2),   mk_e(0, 1, 3, 0, 1, 0));

        issue_w("w_ldi", {LDI, 5'd1, 22'd5}, 32'd5);
        issue_w("w_enc", {ENC, 5'd7, 5'd1, 5'd0, 12'd0}, 32'h15A72);
        issue_w("w_dec", {DEC, 5'd8, 5'd7, 5'd0, 12'd0}, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
